mem_access: RTL and testbench

Memory-access pipeline stage between execute and write-back of the MIPS core. Consumes the execute-stage result as an effective address (or passes it through for non-memory instructions), performs byte/half/word loads and stores against the data memory over a req/ack handshake, and produces aligned, extended write-back data. While a memory transaction is outstanding it raises `stall` to freeze the upstream pipeline.

---
 rtl/mem_access.sv | 172 +++++++++++++++++
 tb/tb_mem_access.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: turns the execute result into a word-aligned data-memory
// request, aligns and extends load data, and raises stall while an access is in flight.
module mem_access (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [5:0]  opcode,
  input  logic        is_load_store,
  input  logic [4:0]  in_dest,
  input  logic        in_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_dest,
  output logic        out_wen,
  output logic        addr_err,
  output logic        stall
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state, state_next;

  // Decode of the incoming instruction.
  logic op_byte, op_half, op_word, op_load, aligned, legal;
  always_comb begin
    op_byte = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
    op_half = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
    op_word = (opcode == OP_LW) || (opcode == OP_SW);
    op_load = ~opcode[3];
    aligned = 1'b1;
    if (op_half) aligned = ~in_result[0];
    if (op_word) aligned = (in_result[1:0] == 2'b00);
    legal = (op_byte | op_half | op_word) & aligned;
  end

  // Store data is replicated across lanes so memory only has to honour the strobes.
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  always_comb begin
    st_wdata = in_store_data;
    st_wstrb = 4'b1111;
    if (op_byte) begin
      st_wdata = {4{in_store_data[7:0]}};
      st_wstrb = 4'b0001 << in_result[1:0];
    end else if (op_half) begin
      st_wdata = {2{in_store_data[15:0]}};
      st_wstrb = in_result[1] ? 4'b1100 : 4'b0011;
    end
    if (op_load) st_wstrb = 4'b0000;
  end

  // Values captured at accept time and used when the ack returns.
  logic [5:0] op_q;
  logic [1:0] lane_q;
  logic [4:0] dest_q;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      OP_LW:   load_data = mem_rdata;
      default: load_data = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  logic accept, complete;

  // FSM next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. Handshake: mem_req rises the cycle after accept and holds with
  // stable address/data until the first cycle mem_ack is seen high; that cycle
  // completes the access and mem_ack in any other cycle has no effect.
  always_comb begin
    accept   = (state == IDLE) && in_valid && is_load_store && legal;
    complete = (state == REQ) && mem_ack;
    stall    = accept || ((state == REQ) && !mem_ack);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'd0;
      mem_wdata <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_dest  <= 5'd0;
      out_wen   <= 1'b0;
      addr_err  <= 1'b0;
      op_q      <= 6'd0;
      lane_q    <= 2'd0;
      dest_q    <= 5'd0;
    end else begin
      out_valid <= 1'b0;
      out_wen   <= 1'b0;
      addr_err  <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (!is_load_store) begin
          out_valid <= 1'b1;
          out_data  <= in_result;
          out_dest  <= in_dest;
          out_wen   <= in_wen;
        end else if (!legal) begin
          out_valid <= 1'b1;
          addr_err  <= 1'b1;
          out_data  <= 32'd0;
          out_dest  <= in_dest;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= ~op_load;
          mem_addr  <= {in_result[31:2], 2'b00};
          mem_wstrb <= st_wstrb;
          mem_wdata <= st_wdata;
          op_q      <= opcode;
          lane_q    <= in_result[1:0];
          dest_q    <= in_dest;
        end
      end else if (complete) begin
        mem_req   <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_dest  <= dest_q;
        out_wen   <= ~op_q[3];
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset-abort sequence, and
// randomized instructions checked against a byte-level reference model.
module tb_mem_access;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [5:0]  opcode;
  logic        is_load_store;
  logic [4:0]  in_dest;
  logic        in_wen;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        addr_err;
  logic        stall;

  mem_access dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
    .in_store_data(in_store_data), .opcode(opcode), .is_load_store(is_load_store),
    .in_dest(in_dest), .in_wen(in_wen), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_valid(out_valid),
    .out_data(out_data), .out_dest(out_dest), .out_wen(out_wen),
    .addr_err(addr_err), .stall(stall)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0]  op;
    logic        ls;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic [4:0]  dest;
    logic        wen;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_wen;
    logic        e_err;
    int          e_stall;
    int          e_lat;
  } vec_t;

  typedef struct {
    int          lat;
    int          stall_cycles;
    int          req_cycles;
    logic        unstable;
    logic        extra;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        wen;
    logic        err;
  } res_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int size, lane;
    bit known, sgn, ld;
    logic [31:0] val;
    r = v;
    r.e_addr = 0; r.e_we = 0; r.e_wstrb = 0; r.e_wdata = 0;
    r.e_data = 0; r.e_wen = 0; r.e_err = 0; r.e_stall = 0; r.e_lat = 1;
    known = 1; sgn = 0; ld = 1; size = 1;
    case (v.op)
      6'h20: begin size = 1; sgn = 1; end
      6'h21: begin size = 2; sgn = 1; end
      6'h23: size = 4;
      6'h24: size = 1;
      6'h25: size = 2;
      6'h28: begin size = 1; ld = 0; end
      6'h29: begin size = 2; ld = 0; end
      6'h2B: begin size = 4; ld = 0; end
      default: known = 0;
    endcase
    if (!v.ls) begin
      r.e_data = v.addr;
      r.e_wen  = v.wen;
    end else if (!known || (v.addr % size) != 0) begin
      r.e_err = 1;
    end else begin
      lane = int'(v.addr % 4);
      r.e_addr  = v.addr - (v.addr % 4);
      r.e_we    = !ld;
      r.e_stall = 1 + v.waits;
      r.e_lat   = 2 + v.waits;
      if (!ld) begin
        for (int i = 0; i < 4; i++) begin
          r.e_wdata[8*i +: 8] = v.sdata[8*(i % size) +: 8];
          if (i >= lane && i < lane + size) r.e_wstrb[i] = 1'b1;
        end
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val = val | (32'(v.rdata[8*(lane+i) +: 8]) << (8*i));
        if (sgn && val[8*size-1]) val = val - (32'd1 << (8*size));
        r.e_data = val;
        r.e_wen  = 1;
      end
    end
    return r;
  endfunction

  // Driver: presents one instruction, plays the memory side, records what it sees.
  task automatic run_instr(input vec_t v, input bit noise, output res_t r);
    int waits;
    bit prev_stall, done;
    r = '{default: 0};
    r.lat = -1;
    waits = 0; prev_stall = 0; done = 0;
    @(negedge sys_clk);
    in_valid = 1; opcode = v.op; is_load_store = v.ls; in_result = v.addr;
    in_store_data = v.sdata; in_dest = v.dest; in_wen = v.wen;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge sys_clk);
        if (!prev_stall) in_valid = 0;
      end
      mem_ack = 0;
      if (mem_req) begin
        r.req_cycles++;
        if (r.req_cycles == 1) begin
          r.addr = mem_addr; r.we = mem_we; r.wstrb = mem_wstrb; r.wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {r.addr, r.we, r.wstrb, r.wdata}) begin
          r.unstable = 1;
        end
        if (waits == v.waits) begin
          mem_ack = 1; mem_rdata = v.rdata;
        end else begin
          waits++; mem_rdata = $urandom;
        end
      end else if (noise) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall) r.stall_cycles++;
      prev_stall = stall;
      if (out_valid) begin
        done = 1; r.lat = c; r.data = out_data; r.dest = out_dest;
        r.wen = out_wen; r.err = addr_err;
      end
    end
    @(negedge sys_clk);
    in_valid = 0; mem_ack = 0;
    #1 r.extra = out_valid | mem_req;
  endtask

  // Scoreboard: expected write-back data goes through exp_q.
  task automatic run_and_check(input vec_t v, input bit noise, input string tag);
    res_t r;
    exp_q.push_back(v.e_data);
    run_instr(v, noise, r);
    check({tag, ".lat"}, r.lat, v.e_lat);
    check({tag, ".stall"}, r.stall_cycles, v.e_stall);
    check({tag, ".pulse"}, r.extra, 0);
    check({tag, ".data"}, r.data, exp_q.pop_front());
    check({tag, ".wen"}, r.wen, v.e_wen);
    check({tag, ".err"}, r.err, v.e_err);
    if (!v.e_err) check({tag, ".dest"}, r.dest, v.dest);
    if (v.e_lat > 1) begin
      check({tag, ".addr"}, r.addr, v.e_addr);
      check({tag, ".we"}, r.we, v.e_we);
      check({tag, ".wstrb"}, r.wstrb, v.e_wstrb);
      check({tag, ".stable"}, r.unstable, 0);
      check({tag, ".reqs"}, r.req_cycles, v.waits + 1);
      if (v.e_we) check({tag, ".wdata"}, r.wdata, v.e_wdata);
    end else begin
      check({tag, ".noreq"}, r.req_cycles, 0);
    end
  endtask

  vec_t tbl[11];
  logic [5:0] legal_ops[8];

  initial begin
    tbl[0]  = '{6'h00, 1'b0, 32'h12345678, 32'h0, 32'h0, 0, 5'd5, 1'b1,
                32'h0, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b1, 1'b0, 0, 1};
    tbl[1]  = '{6'h20, 1'b1, 32'h00001003, 32'h0, 32'h80FF0000, 2, 5'd8, 1'b0,
                32'h1000, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 3, 4};
    tbl[2]  = '{6'h24, 1'b1, 32'h00001003, 32'h0, 32'h80FF0000, 2, 5'd8, 1'b0,
                32'h1000, 1'b0, 4'h0, 32'h0, 32'h00000080, 1'b1, 1'b0, 3, 4};
    tbl[3]  = '{6'h29, 1'b1, 32'h00002002, 32'hAAAABEEF, 32'h0, 0, 5'd3, 1'b1,
                32'h2000, 1'b1, 4'hC, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0, 1, 2};
    tbl[4]  = '{6'h23, 1'b1, 32'h00003002, 32'h0, 32'h0, 0, 5'd4, 1'b1,
                32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1};
    tbl[5]  = '{6'h22, 1'b1, 32'h00003000, 32'h0, 32'h0, 0, 5'd4, 1'b1,
                32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1};
    tbl[6]  = '{6'h2B, 1'b1, 32'h00000010, 32'hCAFEF00D, 32'h0, 1, 5'd9, 1'b0,
                32'h10, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2, 3};
    tbl[7]  = '{6'h25, 1'b1, 32'h00000012, 32'h0, 32'h80010000, 0, 5'd10, 1'b0,
                32'h10, 1'b0, 4'h0, 32'h0, 32'h00008001, 1'b1, 1'b0, 1, 2};
    tbl[8]  = '{6'h21, 1'b1, 32'h00000012, 32'h0, 32'h80010000, 0, 5'd11, 1'b0,
                32'h10, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 1, 2};
    tbl[9]  = '{6'h28, 1'b1, 32'h00000021, 32'h123456AB, 32'h0, 3, 5'd12, 1'b0,
                32'h20, 1'b1, 4'h2, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 4, 5};
    tbl[10] = '{6'h21, 1'b1, 32'h00000013, 32'h0, 32'h0, 0, 5'd13, 1'b1,
                32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1};
    legal_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    rst_n = 0; in_valid = 0; in_result = 0; in_store_data = 0; opcode = 0;
    is_load_store = 0; in_dest = 0; in_wen = 0; mem_rdata = 0; mem_ack = 0;
    repeat (3) @(negedge sys_clk);
    check("rst.ctrl", {mem_req, mem_we, out_valid, out_wen, addr_err, stall}, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.wdata", mem_wdata, 0);
    check("rst.wstrb", mem_wstrb, 0);
    check("rst.out", {out_data, out_dest}, 0);
    rst_n = 1;

    for (int i = 0; i < 11; i++) run_and_check(tbl[i], 1'b0, $sformatf("v%0d", i));

    // Reset while a request is outstanding, then a late ack.
    @(negedge sys_clk);
    in_valid = 1; opcode = 6'h23; is_load_store = 1; in_result = 32'h40; in_dest = 5'd7;
    @(negedge sys_clk);
    check("abort.req_up", mem_req, 1);
    rst_n = 0;
    @(negedge sys_clk);
    check("abort.req_down", mem_req, 0);
    check("abort.novalid", out_valid, 0);
    in_valid = 0; rst_n = 1; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1 check("abort.stall", stall, 0);
    @(negedge sys_clk);
    mem_ack = 0;
    check("abort.late_ack", {mem_req, out_valid}, 0);
    run_and_check(tbl[7], 1'b0, "abort.next");

    // Randomized instructions against the reference model.
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      v = '{default: 0};
      v.op    = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      v.ls    = ($urandom_range(0, 4) != 0);
      v.addr  = $urandom;
      v.sdata = $urandom;
      v.rdata = $urandom;
      v.waits = $urandom_range(0, 3);
      v.dest  = 5'($urandom_range(0, 31));
      v.wen   = 1'($urandom_range(0, 1));
      run_and_check(model(v), 1'b1, $sformatf("r%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
